alu_multicycle: RTL
===================

# alu_multicycle

Parametrised, registered successor to the datapath's combinational ALU. It keeps the existing single-cycle operations and opcodes and adds XOR, signed SLT, and iterative unsigned multiply, divide and remainder. Operands are accepted through a valid/ready handshake and results are returned the same way. It sits in the execute stage of the RISC-V datapath, where the control unit stalls issue while `in_ready` is low.

## Interface
- `WIDTH`, 64: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: operands and opcode are valid this cycle.
- `in_ready`  out  1: block can accept; high only in IDLE.
- `Number1`  in  WIDTH: operand A.
- `Number2`  in  WIDTH: operand B.
- `ALUOp`  in  4: operation code (see Operation).
- `out_valid`  out  1: `Result`, `Zero` and `Illegal` are valid; held until accepted.
- `out_ready`  in  1: consumer accepts the result.
- `Result`  out  WIDTH: registered result.
- `Zero`  out  1: registered, `Result == 0`.
- `Illegal`  out  1: registered, opcode was not in the defined set.

## Operation
- Opcodes, all unsigned unless stated:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1100 NOR
  - 0011 XOR; 0111 SLT (signed, result 1 or 0)
  - 1000 MUL: low WIDTH bits of A*B
  - 1001 DIVU: A/B
  - 1010 REMU: A%B
- Any other opcode: `Result`=0, `Zero`=1, `Illegal`=1, completes via the single-cycle path.
- Width rules:
  - ADD, SUB and MUL wrap modulo 2^WIDTH; no carry or overflow outputs.
  - SLT zero-extends its 1-bit result.
- Divide by zero follows RISC-V: DIVU gives all ones; REMU gives A. Both take the normal iterative latency.
- Operands and opcode are captured on acceptance (`in_valid && in_ready`). Input changes after acceptance have no effect.
- FSM states IDLE, CALC, DONE:
  - IDLE, accept, single-cycle op: result registered -> DONE.
  - IDLE, accept, MUL/DIVU/REMU: load iteration registers, counter=WIDTH-1 -> CALC.
  - CALC: one iteration per cycle, shift-add for MUL and restoring for DIV/REM. When the counter reaches 0, register the result -> DONE.
  - DONE: `out_valid`=1. If `out_ready`=1 -> IDLE, otherwise stay.
  - IDLE without accept: stay.
- `Result`, `Zero` and `Illegal` change only on the transition into DONE and are stable for the whole DONE dwell.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE.
  - `Result`=0, `Zero`=0, `Illegal`=0, `out_valid`=0.
  - `in_ready`=1 from the first cycle after reset.
  - Reset in any state, including mid-CALC, aborts the operation and discards it. No `out_valid` follows.
- Latency is measured from the accept edge to the first cycle with `out_valid`=1:
  - single-cycle ops: 1 cycle
  - MUL/DIVU/REMU: WIDTH+1 cycles
- Throughput:
  - single-cycle ops: one result per 2 cycles.
  - The next accept is possible in the cycle after the DONE handshake. No accept and result handshake ever occur in the same cycle.
- `in_ready` is combinational from state only (IDLE) and never depends on `in_valid`.
- `out_valid` is driven from state only and never depends on `out_ready`.
- If `out_ready` is held low, DONE persists indefinitely and `in_ready` stays 0.

## Test plan
- Reset, then `ALUOp`=0010, A=5, B=7: `out_valid` 1 cycle after accept, `Result`=12, `Zero`=0. Repeat with SUB A=5, B=5: `Result`=0, `Zero`=1.
- MUL, A=0xFFFF_FFFF_FFFF_FFFF, B=3: `in_ready`=0 for the busy interval, `out_valid` exactly 65 cycles after accept, `Result`=0xFFFF_FFFF_FFFF_FFFD. Change A mid-CALC; the result is unchanged.
- DIVU 100/7 gives 14 and REMU 100%7 gives 2, each 65 cycles after accept. DIVU 100/0 gives 0xFFFF_FFFF_FFFF_FFFF; REMU 100%0 gives 100.
- SLT A=0xFFFF_FFFF_FFFF_FFFF (−1), B=1 gives `Result`=1. Opcode 1111 gives `Result`=0, `Zero`=1, `Illegal`=1 at latency 1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises. `Result` stays stable, `in_ready` stays 0, and `in_valid` pulses are ignored. Raise `out_ready`; `in_ready`=1 the next cycle.
- Pull `rst_n` low for one cycle 20 cycles into a MUL. Next cycle: IDLE, `in_ready`=1, outputs 0, and no stale `out_valid` afterwards. Then a fresh ADD 1+1 gives 2.

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
//
// state | meaning
// IDLE  | ready to accept operands
// CALC  | one MUL/DIV/REM iteration per cycle, counting down from WIDTH-1
// DONE  | result held with out_valid until out_ready
module alu_multicycle #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Number1,
  input  logic [WIDTH-1:0] Number2,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;

  logic             accept, is_iter;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt, fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (ALUOp == OP_MUL) || (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUOp)
      4'b0000: alu_res = Number1 & Number2;
      4'b0001: alu_res = Number1 | Number2;
      4'b0010: alu_res = Number1 + Number2;
      4'b0110: alu_res = Number1 - Number2;
      4'b1100: alu_res = ~(Number1 | Number2);
      4'b0011: alu_res = Number1 ^ Number2;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(Number1) < $signed(Number2)};
      default: alu_ill = !is_iter;
    endcase
  end

  // MUL: acc += op_b when op_a LSB set; op_a shifts right, op_b left.
  // DIV/REM: acc is the partial remainder, op_a the dividend turning into the quotient.
  always_comb begin
    mul_sum = acc[WIDTH-1:0] + (op_a[0] ? op_b : '0);
    rem_sh  = {acc[WIDTH-1:0], op_a[WIDTH-1]};
    diff    = rem_sh - {1'b0, op_b};
    ge      = !diff[WIDTH];
    acc_nxt = acc;
    a_nxt   = op_a;
    b_nxt   = op_b;
    if (op == OP_MUL) begin
      acc_nxt = {1'b0, mul_sum};
      a_nxt   = op_a >> 1;
      b_nxt   = op_b << 1;
    end else begin
      acc_nxt = ge ? diff : rem_sh;
      a_nxt   = {op_a[WIDTH-2:0], ge};
    end
    fin = (op == OP_DIVU) ? a_nxt : acc_nxt[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_iter ? CALC : DONE;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      cnt     <= '0;
      Result  <= '0;
      Zero    <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op <= ALUOp;
          if (is_iter) begin
            op_a <= Number1;
            op_b <= Number2;
            acc  <= '0;
            cnt  <= CNT_INIT;
          end else begin
            Result  <= alu_res;
            Zero    <= (alu_res == '0);
            Illegal <= alu_ill;
          end
        end
        CALC: begin
          op_a <= a_nxt;
          op_b <= b_nxt;
          acc  <= acc_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            Result  <= fin;
            Zero    <= (fin == '0);
            Illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
